// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and default operand width.
// Pure declarations; no latency or flow control of its own.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/add_n.sv
// Parametrised ripple-carry adder with carry-in and carry-out.
// Purely combinational, zero latency; no backpressure.
module add_n #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1]   = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier (signed/unsigned); done pulses WIDTH+1 cycles after start.
// Backpressure: start is taken only in IDLE or FINISH and ignored while busy.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last;

    logic                 r_sign;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH:0]     r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_sign;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic                 w_cout;
    logic [2*WIDTH:0]     w_acc_step;
    logic [2*WIDTH-1:0]   w_prod_mag;
    logic [2*WIDTH-1:0]   w_prod_final;

    // Magnitudes fit in WIDTH bits unsigned, including the most negative operand.
    assign w_mag_a = (signed_mode && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign w_mag_b = (signed_mode && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    assign w_sign  = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    add_n #(
        .WIDTH (WIDTH + 1)
    ) u_add (
        .i_a    (r_acc[2*WIDTH:WIDTH]),
        .i_b    ({1'b0, w_addend}),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_step   = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_prod_mag   = w_acc_step[2*WIDTH-1:0];
    assign w_prod_final = r_sign ? (~w_prod_mag + (2*WIDTH)'(1)) : w_prod_mag;
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_sign    <= w_sign;
            r_mcand   <= w_mag_a;
            r_mplier  <= w_mag_b;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (busy) begin
            r_acc    <= w_acc_step;
            // Retired low bits refill the multiplier's top; they never reach bit 0 within WIDTH steps.
            r_mplier <= {r_acc[0], r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_prod_final;
            end
        end
    end

    assign product = r_product;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled only when ready.
REQ-005 The block SHALL have port signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have ports op_a and op_b, input, WIDTH each, multiplicand and multiplier; sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking a valid new product.
REQ-009 The block SHALL have port product, output, 2*WIDTH, result register; holds its value until the next done.

Function
REQ-010 The block SHALL implement states IDLE, RUN, FINISH.
REQ-011 The block SHALL be ready when in IDLE or FINISH, and SHALL accept start only when ready.
REQ-012 On accept at edge E0, the block SHALL:
- latch signed_mode;
- latch |op_a| and |op_b|, taking the magnitude only when signed_mode=1;
- latch result sign = msb(op_a) XOR msb(op_b) when signed, else 0;
- clear the accumulator and the iteration counter;
- enter RUN.
REQ-013 In RUN, each edge SHALL perform one radix-2 shift-add step: add the multiplicand to the upper accumulator half if the multiplier lsb is 1, then shift right one bit, carry included.
REQ-014 After exactly WIDTH RUN steps (edges E1..E_WIDTH), the block SHALL enter FINISH.
REQ-015 At edge E_WIDTH, the block SHALL load product with the accumulator, two's-complement negated if result sign = 1.
REQ-016 done SHALL be high exactly during the cycle after E_WIDTH (state FINISH), giving a latency of WIDTH+1 cycles from start to done.
REQ-017 busy SHALL be high in RUN only, and low in IDLE and FINISH.
REQ-018 In FINISH, start=1 SHALL be accepted (back-to-back operation) and SHALL enter RUN; otherwise FINISH SHALL return to IDLE.
REQ-019 start asserted during RUN SHALL be ignored, with no effect on the latched operands or the result.
REQ-020 The signed result SHALL be exact for all operands, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
REQ-021 The accumulator SHALL be 2*WIDTH+1 bits so that no adder carry is lost.
REQ-022 A zero operand SHALL still take the full WIDTH+1 cycles and SHALL produce product=0 with no negative zero.

Reset
REQ-023 On rst_n low, the block SHALL immediately enter IDLE and force product=0, done=0, busy=0, accumulator=0, counter=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation, with no done pulse afterwards.
REQ-025 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-026 A shared package mult_pkg SHALL hold the state enum type and the default width constant MULT_WIDTH_DEF=4.
REQ-027 The iteration counter width SHALL be $clog2(WIDTH+1), computed locally.
REQ-028 One sub-module, add_n (parametrised WIDTH+1-bit ripple adder with carry-out), SHALL be used for the shift-add step.
REQ-029 The FSM, the magnitude/negate logic and the registers SHALL reside in seq_multiplier.

Verification
REQ-030 With WIDTH=4, unsigned, 15*15: product=0xE1 (225) with done in cycle 5 after start, busy high in cycles 1..4.
REQ-031 With WIDTH=4, signed, -8*-8 (0x8,0x8): product=0x40; signed -3*5 (0xD,0x5): product=0xF1 (-15); signed 7*-1: product=0xF9.
REQ-032 With WIDTH=4, unsigned 6*3, start pulsed again at cycle 2 with 0xF,0xF: product=0x12 with a single done, and the second start is ignored.
REQ-033 With WIDTH=4, rst_n low at cycle 2 of 9*9: product=0, busy=0, no done; a new 2*3 after reset gives product=0x06.
REQ-034 With WIDTH=4, back-to-back 3*4 then start held high in FINISH with 5*5: product=0x0C then 0x19, done pulses 5 cycles apart.
REQ-035 A randomised sweep over all 4-bit pairs in both modes, plus WIDTH=8 corners (255*255=0xFE01, -128*-128=0x4000), SHALL match a reference model.
